mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 131 +++++++++++++
 tb/tb_mem_copy_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: reads src+i, then writes dst+i, for len words, against a single synchronous memory port.
// Optional COPY_FILL_EN macro adds a fill mode that writes a constant to dst+i at one word per cycle.
module mem_copy_engine #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] src,
  input  logic [ADDRWIDTH-1:0] dst,
  input  logic [ADDRWIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_d,
  output logic                 mem_load,
  input  logic [DATAWIDTH-1:0] mem_q
`ifdef COPY_FILL_EN
  ,
  input  logic                 fill,
  input  logic [DATAWIDTH-1:0] fill_val
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] src_q, src_d;
  logic [ADDRWIDTH-1:0] dst_q, dst_d;
  logic [ADDRWIDTH-1:0] len_q, len_d;
  logic [ADDRWIDTH-1:0] i_q, i_d;
  logic [ADDRWIDTH-1:0] i_inc;

`ifdef COPY_FILL_EN
  logic                 fill_q, fill_d;
  logic [DATAWIDTH-1:0] fill_val_q, fill_val_d;
`endif

  // i never exceeds len-1, so i+1 cannot wrap before the compare
  assign i_inc = i_q + ADDRWIDTH'(1);

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      i_q        <= '0;
`ifdef COPY_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      i_q        <= i_d;
`ifdef COPY_FILL_EN
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
`endif
    end
  end

  // Next state, request capture and memory-port decode
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    i_d        = i_q;
`ifdef COPY_FILL_EN
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    mem_addr = '0;
    mem_d    = '0;
    mem_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src;
            dst_d   = dst;
            len_d   = len;
            i_d     = '0;
            state_d = RD;
`ifdef COPY_FILL_EN
            fill_d     = fill;
            fill_val_d = fill_val;
            if (fill) state_d = WR;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_addr = src_q + i_q;
        state_d  = WR;
      end
      WR: begin
        busy     = 1'b1;
        mem_addr = dst_q + i_q;
        mem_load = 1'b1;
        mem_d    = mem_q;
        i_d      = i_inc;
        state_d  = (i_inc < len_q) ? RD : DONE;
`ifdef COPY_FILL_EN
        if (fill_q) begin
          mem_d = fill_val_q;
          if (i_inc < len_q) state_d = WR;
        end
`endif
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural synchronous memory (read-before-write, registered mem_q).
module tb_mem_copy_engine;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src, dst, len;
  logic          busy, done, mem_load;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d, mem_q;
`ifdef COPY_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_val;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_init;

  int errors = 0;
  int checks = 0;

  mem_copy_engine #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_load(mem_load), .mem_q(mem_q)
`ifdef COPY_FILL_EN
    , .fill(fill), .fill_val(fill_val)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: mem_q is the pre-write contents of mem[mem_addr] at the last posedge
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < (1 << AW); k++) mem[k] <= DW'(k);
    end else begin
      mem_q <= mem[mem_addr];
      if (mem_load) mem[mem_addr] <= mem_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and watch it for 2*len+4 cycles; optionally re-pulse start with another src
  task automatic run_req(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                         input logic f, input int poke_cycle, input logic [AW-1:0] poke_src,
                         output int busy_cnt, output int load_cnt, output int done_cnt,
                         output int done_idx, output logic [AW-1:0] addr0, output logic [AW-1:0] addr1);
    int n;
    busy_cnt = 0; load_cnt = 0; done_cnt = 0; done_idx = -1; addr0 = '0; addr1 = '0;
    n = 2 * int'(l) + 4;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
`ifdef COPY_FILL_EN
    fill = f; fill_val = 16'hBEEF;
`else
    if (f) $display("fill request ignored: COPY_FILL_EN not defined");
`endif
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke_cycle) begin start = 1'b1; src = poke_src; end
      if (c == 0) addr0 = mem_addr;
      if (c == 1) addr1 = mem_addr;
      if (busy) busy_cnt++;
      if (mem_load) load_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = c;
      end
    end
    start = 1'b0;
`ifdef COPY_FILL_EN
    fill = 1'b0;
`endif
  endtask

  initial begin
    int bc, lc, dc, di, dcnt;
    logic [AW-1:0] a0, a1;

    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0; mem_init = 1'b1;
`ifdef COPY_FILL_EN
    fill = 1'b0; fill_val = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_load", 32'(mem_load), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_d", 32'(mem_d), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy
    run_req(12'h010, 12'h100, 12'd4, 1'b0, -1, '0, bc, lc, dc, di, a0, a1);
    chk("cp_busy_cycles", 32'(bc), 32'd8);
    chk("cp_load_cycles", 32'(lc), 32'd4);
    chk("cp_done_count", 32'(dc), 32'd1);
    chk("cp_done_idx", 32'(di), 32'd8);
    chk("cp_rd_addr", 32'(a0), 32'h010);
    chk("cp_wr_addr", 32'(a1), 32'h100);
    chk("cp_m100", 32'(mem[12'h100]), 32'h0010);
    chk("cp_m101", 32'(mem[12'h101]), 32'h0011);
    chk("cp_m102", 32'(mem[12'h102]), 32'h0012);
    chk("cp_m103", 32'(mem[12'h103]), 32'h0013);
    chk("cp_m104_untouched", 32'(mem[12'h104]), 32'h0104);

    // Zero length
    run_req(12'h010, 12'h110, 12'd0, 1'b0, -1, '0, bc, lc, dc, di, a0, a1);
    chk("z_busy", 32'(bc), 32'd0);
    chk("z_load", 32'(lc), 32'd0);
    chk("z_done_count", 32'(dc), 32'd1);
    chk("z_done_idx", 32'(di), 32'd0);

    // Source address wrap
    run_req(12'hFFE, 12'h020, 12'd3, 1'b0, -1, '0, bc, lc, dc, di, a0, a1);
    chk("w_m020", 32'(mem[12'h020]), 32'h0FFE);
    chk("w_m021", 32'(mem[12'h021]), 32'h0FFF);
    chk("w_m022", 32'(mem[12'h022]), 32'h0000);
    chk("w_busy", 32'(bc), 32'd6);

    // Start re-asserted mid-transfer with another src
    run_req(12'h050, 12'h180, 12'd4, 1'b0, 2, 12'h070, bc, lc, dc, di, a0, a1);
    chk("rs_m180", 32'(mem[12'h180]), 32'h0050);
    chk("rs_m181", 32'(mem[12'h181]), 32'h0051);
    chk("rs_m182", 32'(mem[12'h182]), 32'h0052);
    chk("rs_m183", 32'(mem[12'h183]), 32'h0053);
    chk("rs_busy", 32'(bc), 32'd8);
    chk("rs_done_count", 32'(dc), 32'd1);

    // Forward overlapping copy smears the first word
    run_req(12'h040, 12'h041, 12'd3, 1'b0, -1, '0, bc, lc, dc, di, a0, a1);
    chk("ov_m041", 32'(mem[12'h041]), 32'h0040);
    chk("ov_m042", 32'(mem[12'h042]), 32'h0040);
    chk("ov_m043", 32'(mem[12'h043]), 32'h0040);

    // Reset in the fifth cycle (RD of word 2) aborts the copy
    @(negedge clk);
    start = 1'b1; src = 12'h030; dst = 12'h300; len = 12'd4;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    chk("ab_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ab_load", 32'(mem_load), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_addr", 32'(mem_addr), 32'h0);
    dcnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ab_no_done", 32'(dcnt), 32'd0);
    chk("ab_m300", 32'(mem[12'h300]), 32'h0030);
    chk("ab_m301", 32'(mem[12'h301]), 32'h0031);
    chk("ab_m302", 32'(mem[12'h302]), 32'h0302);
    chk("ab_m303", 32'(mem[12'h303]), 32'h0303);

`ifdef COPY_FILL_EN
    // Fill mode: one word per cycle
    run_req(12'h000, 12'h200, 12'd3, 1'b1, -1, '0, bc, lc, dc, di, a0, a1);
    chk("f_busy", 32'(bc), 32'd3);
    chk("f_done_idx", 32'(di), 32'd3);
    chk("f_m200", 32'(mem[12'h200]), 32'hBEEF);
    chk("f_m201", 32'(mem[12'h201]), 32'hBEEF);
    chk("f_m202", 32'(mem[12'h202]), 32'hBEEF);
    chk("f_m203_untouched", 32'(mem[12'h203]), 32'h0203);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
